// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Iterative restoring divider for DIV/DIVU/REM/REMU. It retires
//                one quotient bit per cycle, so every operation takes a fixed
//                N+2 cycles from start to done.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int                 c_cnt_w    = $clog2(N + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(N);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [N-1:0]       c_int_min  = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state_q,  w_state_d;
    logic           r_busy_q,   w_busy_d;
    logic           r_done_q,   w_done_d;
    logic [N-1:0]   r_result_q, w_result_d;
    logic           r_is_rem_q, w_is_rem_d;     // op[1]: remainder requested
    logic           r_div0_q,   w_div0_d;
    logic           r_ovf_q,    w_ovf_d;
    logic           r_qsign_q,  w_qsign_d;
    logic           r_rsign_q,  w_rsign_d;
    logic [N-1:0]   r_dvsr_q,   w_dvsr_d;       // divisor magnitude
    logic [N:0]     r_rem_q,    w_rem_d;        // partial remainder, bit N = borrow
    logic [N-1:0]   r_quo_q,    w_quo_d;        // dividend magnitude / quotient bits
    logic [c_cnt_w-1:0] r_cnt_q, w_cnt_d;

    // Operand decode for the accept cycle; op[0]=0 selects the signed variants.
    logic           w_signed;
    logic           w_dvd_neg;
    logic           w_dvs_neg;
    logic [N-1:0]   w_dvd_mag;
    logic [N-1:0]   w_dvs_mag;

    assign w_signed  = ~op[0];
    assign w_dvd_neg = w_signed & dividend[N-1];
    assign w_dvs_neg = w_signed & divisor[N-1];
    assign w_dvd_mag = w_dvd_neg ? (~dividend + 1'b1) : dividend;
    assign w_dvs_mag = w_dvs_neg ? (~divisor + 1'b1) : divisor;

    // One restoring step: shift the next dividend bit in, trial-subtract.
    logic [N:0]     w_shift;
    logic [N:0]     w_diff;

    assign w_shift = {r_rem_q[N-1:0], r_quo_q[N-1]};
    assign w_diff  = w_shift - {1'b0, r_dvsr_q};

    // The remainder never reaches 2^N between steps, so bit N is only a borrow.
    logic           w_unused_rem_msb;
    assign w_unused_rem_msb = r_rem_q[N];

    // Sign fix-up and special-case overrides applied to the finished iteration.
    logic [N-1:0]   w_quo_fix;
    logic [N-1:0]   w_rem_fix;
    logic [N-1:0]   w_final;

    assign w_quo_fix = r_qsign_q ? (~r_quo_q + 1'b1) : r_quo_q;
    assign w_rem_fix = r_rsign_q ? (~r_rem_q[N-1:0] + 1'b1) : r_rem_q[N-1:0];

    // Divide-by-zero leaves the dividend magnitude in the remainder, and the
    // remainder sign fix-up turns it back into the original dividend.
    always_comb begin
        w_final = r_is_rem_q ? w_rem_fix : w_quo_fix;
        if (r_div0_q && !r_is_rem_q) begin
            w_final = '1;
        end else if (r_ovf_q) begin
            w_final = r_is_rem_q ? '0 : c_int_min;
        end
    end

    // Next-state and datapath update for the IDLE/ITER/DONE sequence.
    always_comb begin
        w_state_d  = r_state_q;
        w_busy_d   = r_busy_q;
        w_done_d   = 1'b0;
        w_result_d = r_result_q;
        w_is_rem_d = r_is_rem_q;
        w_div0_d   = r_div0_q;
        w_ovf_d    = r_ovf_q;
        w_qsign_d  = r_qsign_q;
        w_rsign_d  = r_rsign_q;
        w_dvsr_d   = r_dvsr_q;
        w_rem_d    = r_rem_q;
        w_quo_d    = r_quo_q;
        w_cnt_d    = r_cnt_q;
        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_state_d  = S_ITER;
                    w_busy_d   = 1'b1;
                    w_is_rem_d = op[1];
                    w_div0_d   = (divisor == '0);
                    w_ovf_d    = w_signed && (dividend == c_int_min) && (divisor == '1);
                    w_qsign_d  = w_dvd_neg ^ w_dvs_neg;
                    w_rsign_d  = w_dvd_neg;
                    w_dvsr_d   = w_dvs_mag;
                    w_rem_d    = '0;
                    w_quo_d    = w_dvd_mag;
                    w_cnt_d    = '0;
                end
            end
            S_ITER: begin
                if (r_cnt_q == c_cnt_last) begin
                    w_state_d  = S_DONE;
                    w_result_d = w_final;
                    w_done_d   = 1'b1;
                end else begin
                    if (!w_diff[N]) begin
                        w_rem_d = w_diff;
                        w_quo_d = {r_quo_q[N-2:0], 1'b1};
                    end else begin
                        w_rem_d = w_shift;
                        w_quo_d = {r_quo_q[N-2:0], 1'b0};
                    end
                    w_cnt_d = r_cnt_q + c_cnt_one;
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
                w_busy_d  = 1'b0;
            end
            default: begin
                w_state_d = S_IDLE;
                w_busy_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q  <= S_IDLE;
            r_busy_q   <= 1'b0;
            r_done_q   <= 1'b0;
            r_result_q <= '0;
            r_is_rem_q <= 1'b0;
            r_div0_q   <= 1'b0;
            r_ovf_q    <= 1'b0;
            r_qsign_q  <= 1'b0;
            r_rsign_q  <= 1'b0;
            r_dvsr_q   <= '0;
            r_rem_q    <= '0;
            r_quo_q    <= '0;
            r_cnt_q    <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_busy_q   <= w_busy_d;
            r_done_q   <= w_done_d;
            r_result_q <= w_result_d;
            r_is_rem_q <= w_is_rem_d;
            r_div0_q   <= w_div0_d;
            r_ovf_q    <= w_ovf_d;
            r_qsign_q  <= w_qsign_d;
            r_rsign_q  <= w_rsign_d;
            r_dvsr_q   <= w_dvsr_d;
            r_rem_q    <= w_rem_d;
            r_quo_q    <= w_quo_d;
            r_cnt_q    <= w_cnt_d;
        end
    end

    assign busy   = r_busy_q;
    assign done   = r_done_q;
    assign result = r_result_q;

endmodule
`default_nettype wire

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter N, default 32, giving the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port start, input, 1 bit: request a new division; honoured only in IDLE.
REQ-005 SHALL have port op, input, 2 bits: 00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU.
REQ-006 SHALL have port dividend, input, N bits: sampled only in the cycle start is accepted.
REQ-007 SHALL have port divisor, input, N bits: sampled only in the cycle start is accepted.
REQ-008 SHALL have port busy, output, 1 bit: high in ITER and DONE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-010 SHALL have port result, output, N bits: registered quotient or remainder, held until the next done.

Function
REQ-011 SHALL implement FSM states IDLE, ITER and DONE: IDLE->ITER on start; ITER->DONE when the iteration count reaches N; DONE->IDLE unconditionally.
REQ-012 SHALL, on accepting start in IDLE, latch op, the divisor==0 flag, the signed-overflow flag (dividend = 2^(N-1), divisor = all-ones, op = DIV or REM), the quotient sign (operand signs differ), the remainder sign (dividend sign), and both magnitudes (two's-complement absolute value for signed ops, raw value for unsigned ops).
REQ-013 SHALL, on accepting start, clear the (N+1)-bit partial remainder, load the quotient shift register with the dividend magnitude, and clear the counter.
REQ-014 SHALL retire exactly one quotient bit per ITER cycle, MSB first, by restoring division: shift {rem, quo MSB} left, subtract {0, divisor}, keep the difference and shift in 1 if the result is non-negative, otherwise keep the shifted value and shift in 0.
REQ-015 SHALL load result at the ITER->DONE transition and assert done for exactly the one DONE cycle.
REQ-016 SHALL give fixed latency: start accepted at edge k; done high in the cycle following edge k+N+1; the total is N+2 cycles from start to done regardless of operand values.
REQ-017 SHALL, for DIV, negate the quotient magnitude when the quotient sign is set, and for REM negate the remainder magnitude when the remainder sign is set; DIVU and REMU SHALL take no sign fix-up.
REQ-018 SHALL, when the divisor is 0, return all-ones for DIV and DIVU, and return the original dividend (not its magnitude) for REM and REMU.
REQ-019 SHALL, on signed overflow, return 2^(N-1) for DIV and 0 for REM.
REQ-020 SHALL apply the overrides in REQ-018 and REQ-019 without altering the latency of REQ-016.
REQ-021 SHALL ignore start while busy=1, including start asserted in the DONE cycle; internal state and the operands in flight SHALL be unaffected.
REQ-022 SHALL keep result stable from done until the next done; dividend, divisor and op changes after acceptance SHALL have no effect.
REQ-023 SHALL use only the low N bits of the internal remainder for the remainder result; bit N SHALL serve only as the borrow/sign indicator.

Reset
REQ-024 SHALL, when rst_n=0 at a clock edge, force the state to IDLE, busy=0, done=0, result=0, and clear the counter and datapath registers.
REQ-025 SHALL, when reset is applied mid-ITER or in DONE, abort the operation with no done pulse, and SHALL accept a start on the first edge after rst_n returns high.

Verification
REQ-026 SHALL pass: DIVU 100/7 -> result=14, done exactly 34 cycles after start (N=32); REMU 100/7 -> result=2.
REQ-027 SHALL pass: DIV 0xFFFFFFF9 (-7)/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/0xFFFFFFFE (-2) -> 1.
REQ-028 SHALL pass: DIV 5/0 -> 0xFFFFFFFF; REM 0xFFFFFFFB/0 -> 0xFFFFFFFB; DIVU 0/0 -> 0xFFFFFFFF; latency unchanged at 34.
REQ-029 SHALL pass: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0; DIVU with the same operands -> 0.
REQ-030 SHALL pass: start re-pulsed with new operands at cycles 5 and 33 of a busy operation -> ignored, and the first result is correct.
REQ-031 SHALL pass: rst_n low for 1 cycle at ITER cycle 10 -> no done, result=0, and a new DIVU 9/3 started the next cycle -> 3.
